// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder around one full-adder cell with valid/ready handshakes.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port that computes op_a - op_b instead.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_sr_q, sum_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, out_valid_q, out_valid_d;
    logic             sub_en, load, last, fa_sum, fa_carry;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_en = sub;
`else
    assign sub_en = 1'b0;
`endif

    assign load     = state_q == IDLE && in_valid;
    assign last     = cnt_q == CW'(WIDTH - 1);
    assign fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_carry = (a_sr_q[0] & b_sr_q[0]) | (b_sr_q[0] & carry_q) | (carry_q & a_sr_q[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state_q == IDLE;
        busy     = state_q != IDLE;
    end

    // Subtraction is A + ~B + 1, so sub forces the initial carry high.
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        if (load) begin
            a_sr_d  = op_a;
            b_sr_d  = sub_en ? ~op_b : op_b;
            carry_d = sub_en | cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
            carry_d  = fa_carry;
            cnt_d    = cnt_q + CW'(1);
        end
        out_valid_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_sr_q;
    assign cout      = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed-vector bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic c, input logic hold);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = hold;
    endtask

    task automatic wait_done(input string tag, input logic scramble);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (scramble) begin op_a = 8'($urandom); op_b = 8'($urandom); cin = n[0]; end
        end
        check({tag, "_latency"}, 64'(n), 64'd8);
        check({tag, "_valid"}, out_valid, 1'b1);
    endtask

    task automatic finish_handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 1'b0);
        check({tag, "_ready_back"}, in_ready, 1'b1);
        check({tag, "_busy_drop"}, busy, 1'b0);
    endtask

    task automatic add(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [8:0] exp);
        start(a, b, c, 1'b0);
        wait_done(tag, 1'b0);
        check({tag, "_sum"}, sum, exp[7:0]);
        check({tag, "_cout"}, cout, exp[8]);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        finish_handshake(tag);
    endtask

    initial begin
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1'b1);

        add("a5a_33", 8'h5A, 8'h33, 1'b0, 9'h08D);
        add("aff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
        add("aff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        add("a00_00_c", 8'h00, 8'h00, 1'b1, 9'h001);
        add("a80_80", 8'h80, 8'h80, 1'b0, 9'h100);
        add("aaa_55", 8'hAA, 8'h55, 1'b0, 9'h0FF);

        start(8'h5A, 8'h33, 1'b0, 1'b0);
        wait_done("bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sum", sum, 8'h8D);
            check("bp_cout", cout, 1'b0);
            check("bp_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        finish_handshake("bp");

        start(8'h12, 8'h34, 1'b1, 1'b1);
        wait_done("hold", 1'b1);
        check("hold_sum", sum, 8'h47);
        check("hold_cout", cout, 1'b0);
        op_a = 8'h90; op_b = 8'h80; cin = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_gap_ready", in_ready, 1'b1);
        check("hold_gap_busy", busy, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_second_busy", busy, 1'b1);
        wait_done("hold2", 1'b0);
        check("hold2_sum", sum, 8'h10);
        check("hold2_cout", cout, 1'b1);
        finish_handshake("hold2");

        start(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_sum", sum, 8'h00);
        check("arst_cout", cout, 1'b0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        add("post_rst", 8'h01, 8'h02, 1'b0, 9'h003);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        add("sub10_01", 8'h10, 8'h01, 1'b0, 9'h10F);
        add("sub01_02", 8'h01, 8'h02, 1'b1, 9'h0FF);
        sub = 1'b0;
        add("sub0_add", 8'h01, 8'h02, 1'b1, 9'h004);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
